// File: rtl/npu_task_scheduler_pkg.sv
// npu_task_scheduler_pkg: scheduler state encoding, field width, default chunk size and chunk-length helper
package npu_task_scheduler_pkg;
  localparam int FIELD_W   = 32;
  localparam int CHUNK_DEF = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  function automatic logic [FIELD_W-1:0] chunk_len(input logic [FIELD_W-1:0] rem, input logic [FIELD_W-1:0] cb);
    return rem < cb ? rem : cb;
  endfunction
endpackage

// File: rtl/npu_rr_arbiter.sv
// npu_rr_arbiter: round-robin grant from rr pointer; with NPU_SCHED_PRIORITY_EN, masks to highest-priority requests first
module npu_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0]   req,
  input  logic [W-1:0]   ptr,
`ifdef NPU_SCHED_PRIORITY_EN
  input  logic [2*N-1:0] prio,
`endif
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   idx
);
  logic [N-1:0] m;
`ifdef NPU_SCHED_PRIORITY_EN
  logic [1:0] top;
  // keep only requests at the highest priority level present
  always_comb begin
    top = '0;
    m   = '0;
    for (int i = 0; i < N; i++) if (req[i] && prio[2*i +: 2] > top) top = prio[2*i +: 2];
    for (int i = 0; i < N; i++) m[i] = req[i] && prio[2*i +: 2] == top;
  end
`else
  assign m = req;
`endif
  // first masked request at or after ptr, wrapping
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (m[(int'(ptr) + k) % N] && gnt == '0) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/npu_task_scheduler.sv
// npu_task_scheduler: arbitrates task sources onto one engine, chunking each task; NPU_SCHED_PRIORITY_EN adds src_prio
import npu_task_scheduler_pkg::*;
module npu_task_scheduler #(
  parameter int NUM_SRC     = 4,
  parameter int CHUNK_BYTES = CHUNK_DEF,
  parameter int SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*FIELD_W-1:0] src_id,
  input  logic [NUM_SRC*FIELD_W-1:0] src_addr,
  input  logic [NUM_SRC*FIELD_W-1:0] src_size,
`ifdef NPU_SCHED_PRIORITY_EN
  input  logic [NUM_SRC*2-1:0]       src_prio,
`endif
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [FIELD_W-1:0]         cmd_addr,
  output logic [FIELD_W-1:0]         cmd_len,
  output logic                       cmd_last,
  output logic [FIELD_W-1:0]         cmd_id,
  input  logic                       cmp_valid,
  output logic                       done_valid,
  output logic [FIELD_W-1:0]         done_id,
  output logic [SRC_W-1:0]           done_src,
  output logic                       busy
);
  localparam logic [FIELD_W-1:0] CB = FIELD_W'(CHUNK_BYTES);
  state_t               state, state_n;
  logic [SRC_W-1:0]     rr_ptr, win, tsk_src;
  logic [NUM_SRC-1:0]   gnt;
  logic [FIELD_W-1:0]   tsk_id, remaining, win_size, rem_n;
  logic                 accept;
  npu_rr_arbiter #(.N(NUM_SRC), .W(SRC_W)) u_arb (
    .req  (src_valid),
    .ptr  (rr_ptr),
`ifdef NPU_SCHED_PRIORITY_EN
    .prio (src_prio),
`endif
    .gnt  (gnt),
    .idx  (win)
  );
  assign src_ready  = state == IDLE ? gnt : '0;
  assign accept     = |src_ready;
  assign win_size   = src_size[FIELD_W*win +: FIELD_W];
  assign rem_n      = remaining - cmd_len;
  assign cmd_id     = tsk_id;
  assign done_id    = tsk_id;
  assign done_src   = tsk_src;
  assign done_valid = state == DONE;
  assign busy       = state != IDLE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // next-state: zero-size tasks skip straight to DONE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = win_size == '0 ? DONE : ISSUE;
      ISSUE:   if (cmd_ready) state_n = WAIT;
      WAIT:    if (cmp_valid) state_n = cmd_last ? DONE : ISSUE;
      default: state_n = IDLE;
    endcase
  end
  // task capture and registered command generation; next chunk starts where the last one ended
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      tsk_src   <= '0;
      tsk_id    <= '0;
      remaining <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      cmd_last  <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        rr_ptr    <= int'(win) == NUM_SRC - 1 ? '0 : win + 1'b1;
        tsk_src   <= win;
        tsk_id    <= src_id[FIELD_W*win +: FIELD_W];
        remaining <= win_size;
        cmd_valid <= win_size != '0;
        cmd_addr  <= src_addr[FIELD_W*win +: FIELD_W];
        cmd_len   <= chunk_len(win_size, CB);
        cmd_last  <= win_size <= CB;
      end
      if (state == ISSUE && cmd_ready) cmd_valid <= 1'b0;
      if (state == WAIT && cmp_valid) begin
        remaining <= rem_n;
        if (!cmd_last) begin
          cmd_valid <= 1'b1;
          cmd_addr  <= cmd_addr + cmd_len;
          cmd_len   <= chunk_len(rem_n, CB);
          cmd_last  <= rem_n <= CB;
        end
      end
    end
  end
endmodule

// File: tb/tb_npu_task_scheduler.sv
// tb_npu_task_scheduler: directed checks of chunking, zero size, fairness, backpressure and reset
module tb_npu_task_scheduler;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   src_valid = '0;
  logic [3:0]   src_ready;
  logic [127:0] src_id = '0, src_addr = '0, src_size = '0;
  logic         cmd_valid, cmd_ready = 1'b0, cmd_last;
  logic [31:0]  cmd_addr, cmd_len, cmd_id, done_id;
  logic         cmp_valid = 1'b0, done_valid, busy;
  logic [1:0]   done_src;
  int total = 0, bad = 0;
  npu_task_scheduler dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_id(src_id), .src_addr(src_addr), .src_size(src_size),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_last(cmd_last), .cmd_id(cmd_id), .cmp_valid(cmp_valid),
    .done_valid(done_valid), .done_id(done_id), .done_src(done_src), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic offer(input int s, input logic [31:0] id, input logic [31:0] addr, input logic [31:0] size);
    src_id[32*s +: 32]   = id;
    src_addr[32*s +: 32] = addr;
    src_size[32*s +: 32] = size;
    src_valid[s]         = 1'b1;
  endtask
  task automatic serve(input string tag, input logic [31:0] a, input logic [31:0] l, input logic last);
    chk({tag, "_valid"}, 32'(cmd_valid), 1);
    chk({tag, "_addr"}, cmd_addr, a);
    chk({tag, "_len"}, cmd_len, l);
    chk({tag, "_last"}, 32'(cmd_last), 32'(last));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk({tag, "_drop"}, 32'(cmd_valid), 0);
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
  endtask
  task automatic done_chk(input string tag, input logic [31:0] id, input logic [1:0] s);
    chk({tag, "_done"}, 32'(done_valid), 1);
    chk({tag, "_done_id"}, done_id, id);
    chk({tag, "_done_src"}, 32'(done_src), 32'(s));
    tick();
    chk({tag, "_done_gone"}, 32'(done_valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_cmd", 32'(cmd_valid), 0);
    chk("rst_done", 32'(done_valid), 0);
    rst = 1'b0;
    tick();
    offer(0, 32'h11, 32'h1000, 128);
    #1;
    chk("t1_ready", 32'(src_ready), 32'b0001);
    tick();
    src_valid = '0;
    chk("t1_id", cmd_id, 32'h11);
    chk("t1_busy", 32'(busy), 1);
    serve("t1_c0", 32'h1000, 64, 1'b0);
    serve("t1_c1", 32'h1040, 64, 1'b1);
    done_chk("t1", 32'h11, 2'd0);
    offer(1, 32'h22, 32'h2000, 130);
    #1;
    chk("t2_ready", 32'(src_ready), 32'b0010);
    tick();
    src_valid = '0;
    serve("t2_c0", 32'h2000, 64, 1'b0);
    serve("t2_c1", 32'h2040, 64, 1'b0);
    serve("t2_c2", 32'h2080, 2, 1'b1);
    done_chk("t2", 32'h22, 2'd1);
    offer(2, 32'h33, 32'h3000, 0);
    #1;
    chk("t3_ready", 32'(src_ready), 32'b0100);
    tick();
    src_valid = '0;
    chk("t3_nocmd", 32'(cmd_valid), 0);
    done_chk("t3", 32'h33, 2'd2);
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    chk("t3_cmp_ignored", 32'(busy), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) offer(i, 32'hA0 + 32'(i), 32'h100 * 32'(i + 1), 64);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_grant", 32'(src_ready), 32'(1) << (k % 4));
      tick();
      serve("t4_cmd", 32'h100 * 32'(k % 4 + 1), 64, 1'b1);
      chk("t4_done", 32'(done_valid), 1);
      chk("t4_done_src", 32'(done_src), 32'(k % 4));
      tick();
    end
    src_valid = '0;
    offer(3, 32'h55, 32'h5000, 64);
    #1;
    chk("t5_ready", 32'(src_ready), 32'b1000);
    tick();
    src_valid = '0;
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_valid", 32'(cmd_valid), 1);
      chk("t5_hold_addr", cmd_addr, 32'h5000);
      chk("t5_hold_len", cmd_len, 64);
      tick();
    end
    serve("t5_cmd", 32'h5000, 64, 1'b1);
    chk("t5_single", 32'(cmd_valid), 0);
    done_chk("t5", 32'h55, 2'd3);
    offer(2, 32'h66, 32'h6000, 128);
    #1;
    chk("t6_pre_ready", 32'(src_ready), 32'b0100);
    tick();
    src_valid = '0;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t6_in_wait", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("t6_rst_cmd", 32'(cmd_valid), 0);
    chk("t6_rst_addr", cmd_addr, 0);
    chk("t6_rst_len", cmd_len, 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done_valid), 0);
    chk("t6_rst_done_id", done_id, 0);
    rst = 1'b0;
    tick();
    offer(2, 32'h77, 32'h7000, 64);
    offer(3, 32'h88, 32'h8000, 64);
    #1;
    chk("t6_ready", 32'(src_ready), 32'b0100);
    tick();
    src_valid = '0;
    serve("t6_cmd", 32'h7000, 64, 1'b1);
    done_chk("t6", 32'h77, 2'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
